pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Parametrised pipeline control block for the 5-stage CPU. It generalises the fixed stall encoder to N stall requesters, each with a configurable stall depth. It adds a registered flush/redirect path for exceptions and branches, a saturating stall-cycle performance counter, and a watchdog for continuous stalls. It sits beside the IF/ID/EX/MEM/WB stages and drives the stall bus that every pipeline register reads.

Parameters:
STALL_W, 6, stall bus width. Bit 0 = PC hold; bits 1..5 = IF, ID, EX, MEM, WB stage hold.
NREQ, 3, number of stall requesters.
REQ_DEPTH, {4'd3,4'd2,4'd1}, packed NREQ*4 bits, highest stall bit per requester (index 0 in LSBs). The default maps ex/bru/load to 6'b001111 / 6'b000111 / 6'b000011. Every entry must be < STALL_W.
CNT_W, 32, width of the stall-cycle performance counter.
TIMEOUT, 1024, consecutive-stall watchdog threshold. 0 disables the watchdog.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
stallreq  in  NREQ  per-requester stall request, level-sensitive, same-cycle effect
flush_req  in  1  flush/redirect request (exception, mispredict)
flush_pc  in  32  redirect target, sampled with flush_req
perf_clr  in  1  synchronous clear of stall_cycles and stall_timeout
stall  out  STALL_W  stall bus to pipeline registers
flush  out  1  one-cycle flush pulse to all pipeline registers
new_pc  out  32  redirect target, valid while flush=1
stall_cycles  out  CNT_W  count of cycles with stall != 0
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset: the clock is clk; reset is asynchronous and active-high on rst.
  - While rst=1: stall=0, flush=0, new_pc=0, stall_cycles=0, stall_timeout=0, internal run counter=0.
  - Reset mid-stall or mid-flush aborts immediately, with no residual pulse.
- Stall mask:
  - Combinational.
  - For each i with stallreq[i]=1, mask_i = bits [REQ_DEPTH[i]:0] set.
  - raw_stall = OR of all mask_i, which equals the deepest active request. Any combination of requests is legal.
- Flush:
  - flush_req=1 at the rising edge ending cycle N gives flush=1 and new_pc=flush_pc (as sampled) for exactly cycle N+1.
  - flush is a registered output.
  - Back-to-back flush_req in cycles N and N+1 gives flush=1 in N+1 and N+2, each with its own sampled target.
  - new_pc holds its last value when flush=0; it is only meaningful while flush=1.
- Priority for stall:
  - rst first: stall=0.
  - Then a flush cycle (flush=1): stall=0, overriding all requests so the bubble drains.
  - Otherwise stall=raw_stall.
- stall_cycles:
  - At each edge, if perf_clr=1 it is set to 0.
  - Else, if stall != 0 in that cycle, it increments by 1, saturating at all-ones (no wrap).
- Watchdog:
  - The run counter counts consecutive cycles with stall != 0 and is cleared on any cycle with stall == 0.
  - stall_timeout is set at the edge ending the TIMEOUT-th consecutive stalled cycle.
  - Once set it is sticky: it is cleared only by rst or perf_clr.
  - The run counter saturates at TIMEOUT.
  - perf_clr also clears the run counter.
  - With TIMEOUT=0, stall_timeout stays 0.
- Simultaneous events:
  - perf_clr together with a stalled cycle: the clear wins, so the counter reads 0 the next cycle.
  - A flush_req during a stall does not alter stall in the request cycle.
  - stall is forced to 0 only in the flush cycle itself.

Test Plan:
1. Defaults, stallreq=3'b001 (load) for 1 cycle, then 3'b100 (ex) for 1 cycle -> stall=6'b000011 then 6'b001111; stall_cycles=2 afterwards.
2. stallreq=3'b111 -> stall=6'b001111 (deepest wins). stallreq=3'b010 -> 6'b000111.
3. stallreq=3'b100 held; flush_req=1, flush_pc=32'hBFC0_0380 for 1 cycle -> next cycle flush=1, new_pc=32'hBFC0_0380, stall=0. The following cycle has flush=0 and stall=6'b001111.
4. Back-to-back flush_req with targets 32'h100, then 32'h200 -> flush high 2 cycles, new_pc=32'h100 then 32'h200.
5. TIMEOUT=8, stallreq held 7 cycles, released 1 cycle, then held 8 cycles -> stall_timeout rises only after the 8th consecutive stalled cycle of the second run. It stays 1 after the request drops. perf_clr clears it and stall_cycles.
6. CNT_W=4, stall held 20 cycles -> stall_cycles saturates at 4'hF. Assert rst mid-stall -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: N-requester stall bus, registered redirect,
// saturating stall-cycle counter and sticky continuous-stall watchdog.
module pipe_stall_ctrl #(
  parameter int unsigned         STALL_W   = 6,
  parameter int unsigned         NREQ      = 3,
  parameter logic [NREQ*4-1:0]   REQ_DEPTH = {4'd3, 4'd2, 4'd1},
  parameter int unsigned         CNT_W     = 32,
  parameter int unsigned         TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    stallreq,
  input  logic               flush_req,
  input  logic [31:0]        flush_pc,
  input  logic               perf_clr,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic               stall_timeout
);

  localparam int unsigned      RUN_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [STALL_W-1:0] w_raw_stall;
  logic               w_stall_any;
  logic               w_run_hit;
  logic               r_flush;
  logic [31:0]        r_new_pc;
  logic [CNT_W-1:0]   r_stall_cycles;
  logic [RUN_W-1:0]   r_run;
  logic               r_timeout;

  // Each active requester holds PC plus stages up to its depth; OR gives the deepest.
  always_comb begin
    w_raw_stall = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (stallreq[i]) begin
        for (int b = 0; b < int'(STALL_W); b++) begin
          if (b <= int'(REQ_DEPTH[i*4 +: 4])) w_raw_stall[b] = 1'b1;
        end
      end
    end
  end

  // Flush cycle forces a bubble; reset masks the bus asynchronously.
  assign stall       = (rst || r_flush) ? '0 : w_raw_stall;
  assign w_stall_any = |stall;
  assign w_run_hit   = (TIMEOUT != 0) && ((32'(r_run) + 32'd1) >= 32'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush  <= 1'b0;
      r_new_pc <= '0;
    end else begin
      r_flush <= flush_req;
      if (flush_req) r_new_pc <= flush_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (perf_clr) begin
      r_stall_cycles <= '0;
    end else if (w_stall_any && (r_stall_cycles != CNT_MAX)) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  // Run length of consecutive stalled cycles; saturates at the threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run     <= '0;
      r_timeout <= 1'b0;
    end else if (perf_clr) begin
      r_run     <= '0;
      r_timeout <= 1'b0;
    end else if (!w_stall_any) begin
      r_run <= '0;
    end else begin
      if (r_run != RUN_MAX) r_run <= r_run + RUN_W'(1);
      if (w_run_hit) r_timeout <= 1'b1;
    end
  end

  assign flush         = r_flush;
  assign new_pc        = r_new_pc;
  assign stall_cycles  = r_stall_cycles;
  assign stall_timeout = r_timeout;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus random traffic against a
// cycle-level reference model; a second instance runs with the watchdog disabled.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  stallreq;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic        perf_clr;

  logic [5:0]  stall,  stall0;
  logic        flush,  flush0;
  logic [31:0] new_pc, new_pc0;
  logic [3:0]  stall_cycles;
  logic [31:0] cycles0;
  logic        stall_timeout, timeout0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          depth_tbl [3] = '{1, 2, 3};
  bit          m_flush;
  logic [31:0] m_pc;
  int          m_cnt;
  longint      m_cnt32;
  int          m_run;
  bit          m_to;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.CNT_W(4), .TIMEOUT(8)) u_dut (
    .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req),
    .flush_pc(flush_pc), .perf_clr(perf_clr), .stall(stall), .flush(flush),
    .new_pc(new_pc), .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
  );

  pipe_stall_ctrl #(.CNT_W(32), .TIMEOUT(0)) u_dut0 (
    .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req),
    .flush_pc(flush_pc), .perf_clr(perf_clr), .stall(stall0), .flush(flush0),
    .new_pc(new_pc0), .stall_cycles(cycles0), .stall_timeout(timeout0)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Deepest active request sets bits [depth:0]; a flush cycle forces zero.
  function automatic logic [5:0] model_stall(input logic [2:0] req, input bit fl);
    int d;
    d = -1;
    if (fl) return 6'd0;
    for (int i = 0; i < 3; i++)
      if (req[i] && depth_tbl[i] > d) d = depth_tbl[i];
    if (d < 0) return 6'd0;
    return 6'((1 << (d + 1)) - 1);
  endfunction

  task automatic model_reset();
    m_flush = 0; m_pc = '0; m_cnt = 0; m_cnt32 = 0; m_run = 0; m_to = 0;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_stall"},   64'(stall),         64'd0);
    check_eq({tag, "_flush"},   64'(flush),         64'd0);
    check_eq({tag, "_new_pc"},  64'(new_pc),        64'd0);
    check_eq({tag, "_cycles"},  64'(stall_cycles),  64'd0);
    check_eq({tag, "_timeout"}, 64'(stall_timeout), 64'd0);
    check_eq({tag, "_stall0"},  64'(stall0),        64'd0);
    check_eq({tag, "_cycles0"}, 64'(cycles0),       64'd0);
  endtask

  // Entered at posedge+1: drive, check mid-cycle, then advance model at the edge.
  task automatic run_cycle(input logic [2:0] req, input logic fr, input logic [31:0] pc,
                           input logic clr);
    logic [5:0] s;
    stallreq = req; flush_req = fr; flush_pc = pc; perf_clr = clr;
    #2;
    s = model_stall(req, m_flush);
    check_eq("stall",   64'(stall),         64'(s));
    check_eq("flush",   64'(flush),         64'(m_flush));
    if (m_flush) check_eq("new_pc", 64'(new_pc), 64'(m_pc));
    check_eq("cycles",  64'(stall_cycles),  64'(m_cnt));
    check_eq("timeout", 64'(stall_timeout), 64'(m_to));
    check_eq("stall_wd_off",   64'(stall0),   64'(s));
    check_eq("cycles_wd_off",  64'(cycles0),  64'(m_cnt32));
    check_eq("timeout_wd_off", 64'(timeout0), 64'd0);
    @(posedge clk);
    if (clr) begin
      m_cnt = 0; m_cnt32 = 0; m_run = 0; m_to = 0;
    end else if (s != 6'd0) begin
      if (m_cnt < 15) m_cnt++;
      m_cnt32++;
      if (m_run < 8) m_run++;
      if (m_run >= 8) m_to = 1;
    end else begin
      m_run = 0;
    end
    m_flush = fr;
    if (fr) m_pc = pc;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stallreq = '0; flush_req = 0; flush_pc = '0; perf_clr = 0;
    #2;
    check_zero("rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // Single requesters, then count
    run_cycle(3'b001, 0, '0, 0);
    run_cycle(3'b100, 0, '0, 0);
    run_cycle(3'b000, 0, '0, 0);
    check_eq("tp1_cycles", 64'(stall_cycles), 64'd2);

    // Deepest request wins
    run_cycle(3'b111, 0, '0, 0);
    run_cycle(3'b010, 0, '0, 0);
    run_cycle(3'b000, 0, '0, 0);

    // Flush over a held stall, then back-to-back flushes
    run_cycle(3'b100, 1, 32'hBFC0_0380, 0);
    run_cycle(3'b100, 0, '0, 0);
    run_cycle(3'b100, 0, '0, 0);
    run_cycle(3'b000, 1, 32'h100, 0);
    run_cycle(3'b000, 1, 32'h200, 0);
    run_cycle(3'b000, 0, '0, 0);
    run_cycle(3'b000, 0, '0, 0);

    // Watchdog: run of 7, gap, run of 8, sticky, then perf_clr
    do_reset();
    for (int i = 0; i < 7; i++) run_cycle(3'b100, 0, '0, 0);
    run_cycle(3'b000, 0, '0, 0);
    check_eq("wd_short_run", 64'(stall_timeout), 64'd0);
    for (int i = 0; i < 8; i++) run_cycle(3'b001, 0, '0, 0);
    check_eq("wd_fired", 64'(stall_timeout), 64'd1);
    run_cycle(3'b000, 0, '0, 0);
    run_cycle(3'b000, 0, '0, 1);
    check_eq("wd_cleared", 64'(stall_timeout), 64'd0);
    run_cycle(3'b010, 0, '0, 1);
    run_cycle(3'b000, 0, '0, 0);
    check_eq("clr_beats_stall", 64'(stall_cycles), 64'd0);

    // Counter saturation, then asynchronous reset mid-stall and mid-flush
    for (int i = 0; i < 20; i++) run_cycle(3'b100, 0, '0, 0);
    check_eq("cnt_sat", 64'(stall_cycles), 64'hF);
    run_cycle(3'b100, 1, 32'hDEAD_BEEF, 0);
    stallreq = 3'b100; flush_req = 0; perf_clr = 0;
    #2;
    check_eq("pre_rst_flush", 64'(flush), 64'd1);
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    stallreq = '0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      run_cycle(3'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0),
                $urandom, ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
